// File: rtl/dual_read_port_fifo_pkg.sv
// rtl/dual_read_port_fifo_pkg.sv - shared types and defaults for the dual read port FIFO
// Purpose: default word width and the read-port turn encoding.
// Ports: none (package reg_port_pkg).
package reg_port_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    PORT1 = 1'b0,
    PORT2 = 1'b1
  } port_sel_t;

endpackage

// File: rtl/dual_read_port_fifo_if.sv
// rtl/dual_read_port_fifo_if.sv - producer/consumer bundle for the dual read port FIFO
// Purpose: groups the write port, both read ports and the occupancy output.
// Ports:
//   wr_data/wr_valid/wr_ready       single producer handshake
//   rd1_data/rd1_valid/rd1_ready    consumer 1 handshake
//   rd2_data/rd2_valid/rd2_ready    consumer 2 handshake
//   count                           occupancy 0..DEPTH
// Modports: master = producer/consumer side, slave = FIFO side.
interface dual_read_port_fifo_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_valid;
  logic              rd1_ready;
  logic [DATA_W-1:0] rd2_data;
  logic              rd2_valid;
  logic              rd2_ready;
  logic [CW-1:0]     count;

  modport master (
    output wr_data, wr_valid, rd1_ready, rd2_ready,
    input  wr_ready, rd1_data, rd1_valid, rd2_data, rd2_valid, count
  );

  modport slave (
    input  wr_data, wr_valid, rd1_ready, rd2_ready,
    output wr_ready, rd1_data, rd1_valid, rd2_data, rd2_valid, count
  );

endinterface

// File: rtl/dual_read_port_fifo_mem.sv
// rtl/dual_read_port_fifo_mem.sv - DEPTH x DATA_W register array for the FIFO
// Purpose: storage with synchronous write and asynchronous read, no reset.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
module reg_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/dual_read_port_fifo.sv
// rtl/dual_read_port_fifo.sv - single-write FIFO feeding two read ports in alternation
// Purpose: buffers producer words and offers the head word to port 1, then port 2,
//   then port 1 again, advancing the turn on every pop.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave modport of dual_read_port_fifo_if (write port, two read ports, count)
// Configuration: define ALT_SKIP_EN for work-conserving mode, where a stalled
//   scheduled port lets the other ready port take the head without losing its turn.
module dual_read_port_fifo
  import reg_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  dual_read_port_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  port_sel_t         r_turn;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop1;
  logic              w_pop2;
  logic              w_pop;
  logic              w_advance;
  logic              w_rd1_valid;
  logic              w_rd2_valid;
  logic [DATA_W-1:0] w_head;

  // Occupancy alone decides full/empty so equal pointers are never ambiguous.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A full FIFO refuses the write even when a pop frees a slot this cycle.
  assign w_push = bus.wr_valid && !w_full;

`ifdef ALT_SKIP_EN
  // The off-turn port may take the head when the scheduled port is not ready;
  // the turn only advances when the scheduled port itself pops.
  assign w_rd1_valid = !w_empty && ((r_turn == PORT1) || !bus.rd2_ready);
  assign w_rd2_valid = !w_empty && ((r_turn == PORT2) || !bus.rd1_ready);
  assign w_advance   = (r_turn == PORT1) ? w_pop1 : w_pop2;
`else
  assign w_rd1_valid = !w_empty && (r_turn == PORT1);
  assign w_rd2_valid = !w_empty && (r_turn == PORT2);
  assign w_advance   = w_pop;
`endif

  // At most one of these can be high: the two valids never overlap with both readies set.
  assign w_pop1 = w_rd1_valid && bus.rd1_ready;
  assign w_pop2 = w_rd2_valid && bus.rd2_ready;
  assign w_pop  = w_pop1 || w_pop2;

  reg_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (bus.wr_data),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_turn   <= PORT1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_advance) begin
        r_turn <= (r_turn == PORT1) ? PORT2 : PORT1;
      end
    end
  end

  assign bus.wr_ready  = !w_full;
  assign bus.rd1_valid = w_rd1_valid;
  assign bus.rd2_valid = w_rd2_valid;
  assign bus.rd1_data  = w_rd1_valid ? w_head : '0;
  assign bus.rd2_data  = w_rd2_valid ? w_head : '0;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_dual_read_port_fifo.sv
// tb/tb_dual_read_port_fifo.sv - directed self-checking bench for dual_read_port_fifo
module tb_dual_read_port_fifo;

  logic clk;
  logic reset;
  int   vec;
  int   err;

  dual_read_port_fifo_if #(.DATA_W(16), .DEPTH(4)) bus ();

  dual_read_port_fifo #(.DATA_W(16), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 16'h0;
    bus.rd1_ready = 1'b0;
    bus.rd2_ready = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic push_words(input logic [15:0] a, input logic [15:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_data  = a;
    tick();
    bus.wr_data  = b;
    tick();
    bus.wr_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    vec++; if (bus.wr_ready !== 1'b1) begin err++; $display("FAIL rst0_wr_ready got %b want 1", bus.wr_ready); end
    vec++; if (bus.rd1_valid !== 1'b0 || bus.rd2_valid !== 1'b0) begin err++; $display("FAIL rst0_valid got %b%b want 00", bus.rd1_valid, bus.rd2_valid); end
    vec++; if (bus.count !== 3'd0) begin err++; $display("FAIL rst0_count got %0d want 0", bus.count); end
    push_words(16'hD001, 16'hD002);
    bus.rd1_ready = 1'b1;
    tick();
    bus.rd1_ready = 1'b0;
    reset = 1'b0;
    tick();
    vec++; if (bus.wr_ready !== 1'b1) begin err++; $display("FAIL rst_wr_ready got %b want 1", bus.wr_ready); end
    vec++; if (bus.rd1_valid !== 1'b0 || bus.rd2_valid !== 1'b0) begin err++; $display("FAIL rst_valid got %b%b want 00", bus.rd1_valid, bus.rd2_valid); end
    vec++; if (bus.rd1_data !== 16'h0 || bus.rd2_data !== 16'h0) begin err++; $display("FAIL rst_data got %h/%h want 0000/0000", bus.rd1_data, bus.rd2_data); end
    vec++; if (bus.count !== 3'd0) begin err++; $display("FAIL rst_count got %0d want 0", bus.count); end
    reset = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hD003;
    tick();
    bus.wr_valid = 1'b0;
    #1;
    vec++; if (bus.rd1_valid !== 1'b1 || bus.rd1_data !== 16'hD003) begin err++; $display("FAIL rst_next_port1 got v=%b d=%h want v=1 d=d003", bus.rd1_valid, bus.rd1_data); end
    vec++; if (bus.count !== 3'd1) begin err++; $display("FAIL rst_next_count got %0d want 1", bus.count); end
  endtask

  task automatic test_alternation();
    reset_dut();
    bus.rd1_ready = 1'b1;
    bus.rd2_ready = 1'b1;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 16'hA001;
    #1;
    vec++; if (bus.rd1_valid !== 1'b0 || bus.rd2_valid !== 1'b0) begin err++; $display("FAIL alt_no_bypass got %b%b want 00", bus.rd1_valid, bus.rd2_valid); end
    tick();
    bus.wr_data = 16'hA002;
    #1;
    vec++; if (bus.rd1_valid !== 1'b1 || bus.rd1_data !== 16'hA001) begin err++; $display("FAIL alt_w1 got v=%b d=%h want v=1 d=a001", bus.rd1_valid, bus.rd1_data); end
    tick();
    bus.wr_data = 16'hA003;
    #1;
    vec++; if (bus.rd2_valid !== 1'b1 || bus.rd2_data !== 16'hA002 || bus.rd1_valid !== 1'b0) begin err++; $display("FAIL alt_w2 got v2=%b d2=%h v1=%b want 1/a002/0", bus.rd2_valid, bus.rd2_data, bus.rd1_valid); end
    tick();
    bus.wr_valid = 1'b0;
    #1;
    vec++; if (bus.rd1_valid !== 1'b1 || bus.rd1_data !== 16'hA003) begin err++; $display("FAIL alt_w3 got v=%b d=%h want v=1 d=a003", bus.rd1_valid, bus.rd1_data); end
    tick();
    vec++; if (bus.count !== 3'd0 || bus.rd1_valid !== 1'b0 || bus.rd2_valid !== 1'b0) begin err++; $display("FAIL alt_end got count=%0d v=%b%b want 0/00", bus.count, bus.rd1_valid, bus.rd2_valid); end
  endtask

  task automatic test_full();
    reset_dut();
    bus.wr_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.wr_data = 16'(i);
      tick();
    end
    vec++; if (bus.count !== 3'd4) begin err++; $display("FAIL full_count got %0d want 4", bus.count); end
    vec++; if (bus.wr_ready !== 1'b0) begin err++; $display("FAIL full_wr_ready got %b want 0", bus.wr_ready); end
    bus.wr_data   = 16'h0005;
    bus.rd1_ready = 1'b1;
    #1;
    vec++; if (bus.rd1_valid !== 1'b1 || bus.rd1_data !== 16'h0001) begin err++; $display("FAIL full_pop got v=%b d=%h want v=1 d=0001", bus.rd1_valid, bus.rd1_data); end
    tick();
    bus.wr_valid  = 1'b0;
    bus.rd1_ready = 1'b0;
    bus.rd2_ready = 1'b1;
    #1;
    vec++; if (bus.count !== 3'd3) begin err++; $display("FAIL full_after_count got %0d want 3", bus.count); end
    vec++; if (bus.rd2_valid !== 1'b1 || bus.rd2_data !== 16'h0002) begin err++; $display("FAIL full_drain2 got v=%b d=%h want v=1 d=0002", bus.rd2_valid, bus.rd2_data); end
    tick();
    bus.rd2_ready = 1'b0;
    bus.rd1_ready = 1'b1;
    #1;
    vec++; if (bus.rd1_valid !== 1'b1 || bus.rd1_data !== 16'h0003) begin err++; $display("FAIL full_drain3 got v=%b d=%h want v=1 d=0003", bus.rd1_valid, bus.rd1_data); end
    tick();
    bus.rd1_ready = 1'b0;
    bus.rd2_ready = 1'b1;
    #1;
    vec++; if (bus.rd2_valid !== 1'b1 || bus.rd2_data !== 16'h0004) begin err++; $display("FAIL full_drain4 got v=%b d=%h want v=1 d=0004", bus.rd2_valid, bus.rd2_data); end
    tick();
    vec++; if (bus.count !== 3'd0 || bus.rd1_valid !== 1'b0) begin err++; $display("FAIL full_no_0005 got count=%0d v1=%b want 0/0", bus.count, bus.rd1_valid); end
  endtask

  task automatic test_stall();
    reset_dut();
    push_words(16'hB001, 16'hB002);
`ifdef ALT_SKIP_EN
    bus.rd1_ready = 1'b0;
    bus.rd2_ready = 1'b1;
    #1;
    vec++; if (bus.rd2_valid !== 1'b1 || bus.rd2_data !== 16'hB001) begin err++; $display("FAIL skip_port2 got v=%b d=%h want v=1 d=b001", bus.rd2_valid, bus.rd2_data); end
    tick();
    bus.rd2_ready = 1'b0;
    bus.rd1_ready = 1'b1;
    #1;
    vec++; if (bus.count !== 3'd1) begin err++; $display("FAIL skip_count got %0d want 1", bus.count); end
    vec++; if (bus.rd1_valid !== 1'b1 || bus.rd1_data !== 16'hB002) begin err++; $display("FAIL skip_turn_kept got v=%b d=%h want v=1 d=b002", bus.rd1_valid, bus.rd1_data); end
    tick();
    vec++; if (bus.count !== 3'd0) begin err++; $display("FAIL skip_end_count got %0d want 0", bus.count); end
`else
    bus.rd1_ready = 1'b0;
    bus.rd2_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vec++; if (bus.rd1_valid !== 1'b1 || bus.rd1_data !== 16'hB001) begin err++; $display("FAIL stall_hold c=%0d got v=%b d=%h want v=1 d=b001", c, bus.rd1_valid, bus.rd1_data); end
      vec++; if (bus.rd2_valid !== 1'b0 || bus.count !== 3'd2) begin err++; $display("FAIL stall_other c=%0d got v2=%b count=%0d want 0/2", c, bus.rd2_valid, bus.count); end
      tick();
    end
    bus.rd1_ready = 1'b1;
    bus.rd2_ready = 1'b0;
    tick();
    vec++; if (bus.rd2_valid !== 1'b1 || bus.rd2_data !== 16'hB002) begin err++; $display("FAIL stall_release got v=%b d=%h want v=1 d=b002", bus.rd2_valid, bus.rd2_data); end
`endif
  endtask

  task automatic test_simul();
    reset_dut();
    push_words(16'hC001, 16'hC002);
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 16'hC003;
    bus.rd1_ready = 1'b1;
    #1;
    vec++; if (bus.rd1_valid !== 1'b1 || bus.rd1_data !== 16'hC001) begin err++; $display("FAIL simul_oldest got v=%b d=%h want v=1 d=c001", bus.rd1_valid, bus.rd1_data); end
    tick();
    idle_inputs();
    #1;
    vec++; if (bus.count !== 3'd2) begin err++; $display("FAIL simul_count got %0d want 2", bus.count); end
    vec++; if (bus.rd2_valid !== 1'b1 || bus.rd2_data !== 16'hC002) begin err++; $display("FAIL simul_next got v=%b d=%h want v=1 d=c002", bus.rd2_valid, bus.rd2_data); end
  endtask

  task automatic test_wrap();
    logic [15:0] q[$];
    logic        mt;
    logic        ne, wv, r1, r2, ev1, ev2, p1, p2, pu;
    logic [15:0] eh, got;
    int          pushed;
    int          popped;
    reset_dut();
    mt = 1'b0;
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
      wv = (pushed < 10) && ($urandom_range(0, 3) != 0);
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      bus.wr_valid  = wv;
      bus.wr_data   = 16'(16'h0100 + pushed);
      bus.rd1_ready = r1;
      bus.rd2_ready = r2;
      #1;
      ne = (q.size() != 0);
`ifdef ALT_SKIP_EN
      ev1 = ne && (mt == 1'b0 || !r2);
      ev2 = ne && (mt == 1'b1 || !r1);
`else
      ev1 = ne && (mt == 1'b0);
      ev2 = ne && (mt == 1'b1);
`endif
      eh = ne ? q[0] : 16'h0;
      vec++; if (bus.rd1_valid !== ev1 || bus.rd2_valid !== ev2) begin err++; $display("FAIL wrap_valid cyc=%0d got %b%b want %b%b", cyc, bus.rd1_valid, bus.rd2_valid, ev1, ev2); end
      vec++; if (bus.rd1_data !== (ev1 ? eh : 16'h0) || bus.rd2_data !== (ev2 ? eh : 16'h0)) begin err++; $display("FAIL wrap_data cyc=%0d got %h/%h want head %h", cyc, bus.rd1_data, bus.rd2_data, eh); end
      vec++; if (bus.count !== 3'(q.size()) || bus.wr_ready !== (q.size() < 4)) begin err++; $display("FAIL wrap_count cyc=%0d got count=%0d rdy=%b want %0d", cyc, bus.count, bus.wr_ready, q.size()); end
      p1 = ev1 && r1;
      p2 = ev2 && r2;
      pu = wv && (q.size() < 4);
      if (p1 || p2) begin
        got = p1 ? bus.rd1_data : bus.rd2_data;
        vec++; if (got !== 16'(16'h0100 + popped)) begin err++; $display("FAIL wrap_order cyc=%0d got %h want %h", cyc, got, 16'(16'h0100 + popped)); end
        void'(q.pop_front());
        popped++;
`ifdef ALT_SKIP_EN
        if ((mt == 1'b0 && p1) || (mt == 1'b1 && p2)) mt = ~mt;
`else
        mt = ~mt;
`endif
      end
      if (pu) begin
        q.push_back(16'(16'h0100 + pushed));
        pushed++;
      end
      tick();
    end
    idle_inputs();
    vec++; if (popped != 10) begin err++; $display("FAIL wrap_budget got %0d words want 10", popped); end
    vec++; if (bus.count !== 3'd0) begin err++; $display("FAIL wrap_final_count got %0d want 0", bus.count); end
  endtask

  initial begin
    vec = 0;
    err = 0;
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_alternation();
    test_full();
    test_stall();
    test_simul();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
